// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I/M decode stage with a 2-entry skid buffer
module rv_decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int EN_M_EXT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_inst,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic [2:0]            out_mem_op,
    output logic [3:0]            out_alu_op,
    output logic [2:0]            out_alu_src,
    output logic [2:0]            out_imm_op,
    output logic [2:0]            out_branch,
    output logic [3:0]            out_md_op,
    output logic                  out_illegal
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] mem_op;
        logic [3:0] alu_op;
        logic [2:0] alu_src;
        logic [2:0] imm_op;
        logic [2:0] branch;
        logic [3:0] md_op;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        ctrl_t                 ctrl;
    } entry_t;

    ctrl_t      dec;
    entry_t     in_entry;
    entry_t     m_q, m_d, s_q, s_d;
    logic       m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] alu_std;
    logic       accept, fire;

    assign f3      = in_inst[14:12];
    assign f7      = in_inst[31:25];
    // funct3 maps straight onto alu_op except sltu, which has its own code
    assign alu_std = (f3 == 3'b011) ? 4'b1010 : {1'b0, f3};

    always_comb begin
        dec = '0;
        if (in_inst[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (in_inst[6:2])
                5'b01100: begin
                    if (f7 == 7'b0000000) begin
                        dec.reg_write = 1'b1;
                        dec.alu_op    = alu_std;
                    end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                        dec.reg_write = 1'b1;
                        dec.alu_op    = {1'b1, f3};
                    end else if (f7 == 7'b0000001 && EN_M_EXT != 0) begin
                        dec.reg_write = 1'b1;
                        dec.md_op     = {1'b1, f3};
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                5'b00100: begin
                    dec.alu_src   = 3'b010;
                    dec.imm_op    = 3'b001;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = alu_std;
                    if (f3 == 3'b001 && f7 != 7'b0000000) dec.illegal = 1'b1;
                    if (f3 == 3'b101) begin
                        if (f7 == 7'b0100000)      dec.alu_op  = 4'b1101;
                        else if (f7 != 7'b0000000) dec.illegal = 1'b1;
                    end
                end
                5'b00000: begin
                    dec.alu_src    = 3'b010;
                    dec.imm_op     = 3'b001;
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.mem_op     = f3 + 3'd1;
                    if (f3 == 3'b011 || f3[2:1] == 2'b11) dec.illegal = 1'b1;
                end
                5'b01000: begin
                    dec.alu_src   = 3'b010;
                    dec.imm_op    = 3'b011;
                    dec.mem_write = 1'b1;
                    dec.mem_op    = f3 + 3'd1;
                    if (f3 > 3'b010) dec.illegal = 1'b1;
                end
                5'b11000: begin
                    dec.imm_op = 3'b100;
                    dec.alu_op = f3[1] ? 4'b1010 : 4'b1000;
                    dec.branch = {1'b1, f3[2], f3[0]};
                    if (f3[2:1] == 2'b01) dec.illegal = 1'b1;
                end
                5'b11011: begin
                    dec.alu_src   = 3'b101;
                    dec.imm_op    = 3'b101;
                    dec.branch    = 3'b001;
                    dec.reg_write = 1'b1;
                end
                5'b11001: begin
                    dec.alu_src   = 3'b101;
                    dec.imm_op    = 3'b001;
                    dec.branch    = 3'b010;
                    dec.reg_write = 1'b1;
                    if (f3 != 3'b000) dec.illegal = 1'b1;
                end
                5'b01101: begin
                    dec.alu_op    = 4'b0011;
                    dec.alu_src   = 3'b010;
                    dec.imm_op    = 3'b010;
                    dec.reg_write = 1'b1;
                end
                5'b00101: begin
                    dec.alu_src   = 3'b011;
                    dec.imm_op    = 3'b010;
                    dec.reg_write = 1'b1;
                end
                5'b00011: begin
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        // illegal ops must not cause any architectural side effect downstream
        if (dec.illegal) begin
            dec.reg_write  = 1'b0;
            dec.mem_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.mem_op     = 3'b000;
            dec.branch     = 3'b000;
            dec.md_op      = 4'b0000;
        end
        if (in_inst[11:7] == 5'd0) dec.reg_write = 1'b0;
    end

    assign in_entry = '{pc: in_pc, inst: in_inst, ctrl: dec};
    assign in_ready = !rst && !s_valid_q;
    assign accept   = in_valid && in_ready;
    assign fire     = m_valid_q && out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || fire) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_d       = in_entry;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_d       = in_entry;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign out_valid      = m_valid_q;
    assign out_pc         = m_q.pc;
    assign out_inst       = m_q.inst;
    assign out_rs1        = m_q.inst[19:15];
    assign out_rs2        = m_q.inst[24:20];
    assign out_rd         = m_q.inst[11:7];
    assign out_reg_write  = m_q.ctrl.reg_write;
    assign out_mem_write  = m_q.ctrl.mem_write;
    assign out_mem_to_reg = m_q.ctrl.mem_to_reg;
    assign out_mem_op     = m_q.ctrl.mem_op;
    assign out_alu_op     = m_q.ctrl.alu_op;
    assign out_alu_src    = m_q.ctrl.alu_src;
    assign out_imm_op     = m_q.ctrl.imm_op;
    assign out_branch     = m_q.ctrl.branch;
    assign out_md_op      = m_q.ctrl.md_op;
    assign out_illegal    = m_q.ctrl.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - bench for rv_decode_stage with and without the M extension
module tb_rv_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, out_valid, in_ready_b, out_valid_b;
    logic [31:0] out_pc, out_inst, out_pc_b, out_inst_b;
    logic [4:0]  out_rs1, out_rs2, out_rd, out_rs1_b, out_rs2_b, out_rd_b;
    logic        out_reg_write, out_mem_write, out_mem_to_reg, out_illegal;
    logic        out_reg_write_b, out_mem_write_b, out_mem_to_reg_b, out_illegal_b;
    logic [2:0]  out_mem_op, out_alu_src, out_imm_op, out_branch;
    logic [2:0]  out_mem_op_b, out_alu_src_b, out_imm_op_b, out_branch_b;
    logic [3:0]  out_alu_op, out_md_op, out_alu_op_b, out_md_op_b;
    logic [23:0] ctrl_a, ctrl_b;

    int    n_vec = 0;
    int    n_err = 0;
    item_t srcq[$];
    item_t expq[$];
    logic [31:0] next_pc = 32'h0000_1000;
    logic [31:0] pc0;

    always #5 clk = ~clk;

    rv_decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .EN_M_EXT(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_op(out_mem_op), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_imm_op(out_imm_op), .out_branch(out_branch), .out_md_op(out_md_op), .out_illegal(out_illegal)
    );

    rv_decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .EN_M_EXT(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_pc(out_pc_b), .out_inst(out_inst_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_rd(out_rd_b),
        .out_reg_write(out_reg_write_b), .out_mem_write(out_mem_write_b), .out_mem_to_reg(out_mem_to_reg_b),
        .out_mem_op(out_mem_op_b), .out_alu_op(out_alu_op_b), .out_alu_src(out_alu_src_b),
        .out_imm_op(out_imm_op_b), .out_branch(out_branch_b), .out_md_op(out_md_op_b), .out_illegal(out_illegal_b)
    );

    assign ctrl_a = {out_reg_write, out_mem_write, out_mem_to_reg, out_mem_op, out_alu_op,
                     out_alu_src, out_imm_op, out_branch, out_md_op, out_illegal};
    assign ctrl_b = {out_reg_write_b, out_mem_write_b, out_mem_to_reg_b, out_mem_op_b, out_alu_op_b,
                     out_alu_src_b, out_imm_op_b, out_branch_b, out_md_op_b, out_illegal_b};

    // Reference decode, mnemonic by mnemonic; returns the ctrl_a field layout
    function automatic logic [23:0] ref_dec(input logic [31:0] w, input bit m_en);
        logic [3:0] alu_tab [8];
        logic [2:0] br_tab [8];
        logic [6:0] op, f7;
        logic [2:0] f3, mop, src, imm, br;
        logic [3:0] alu, md;
        logic       rw, mw, mr, ill;
        alu_tab = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd4, 4'd5, 4'd6, 4'd7};
        br_tab  = '{3'd4, 3'd5, 3'd0, 3'd0, 3'd6, 3'd7, 3'd6, 3'd7};
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        rw = 0; mw = 0; mr = 0; ill = 0; mop = 0; src = 0; imm = 0; br = 0; alu = 0; md = 0;
        case (op)
            7'h33: if (f7 == 7'h00) begin rw = 1; alu = alu_tab[f3]; end
                   else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin rw = 1; alu = alu_tab[f3] + 4'd8; end
                   else if (f7 == 7'h01 && m_en) begin rw = 1; md = 4'd8 + {1'b0, f3}; end
                   else ill = 1;
            7'h13: begin
                src = 2; imm = 1; rw = 1; alu = alu_tab[f3];
                if (f3 == 1 && f7 != 0) ill = 1;
                if (f3 == 5 && f7 == 7'h20) alu = 4'd13;
                else if (f3 == 5 && f7 != 0) ill = 1;
            end
            7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                       rw = 1; mr = 1; src = 2; imm = 1; mop = f3 + 3'd1;
                   end else ill = 1;
            7'h23: if (f3 <= 2) begin mw = 1; src = 2; imm = 3; mop = f3 + 3'd1; end
                   else ill = 1;
            7'h63: if (f3 != 2 && f3 != 3) begin imm = 4; br = br_tab[f3]; alu = (f3 >= 6) ? 4'd10 : 4'd8; end
                   else ill = 1;
            7'h6F: begin src = 5; imm = 5; br = 1; rw = 1; end
            7'h67: if (f3 == 0) begin src = 5; imm = 1; br = 2; rw = 1; end
                   else ill = 1;
            7'h37: begin alu = 3; src = 2; imm = 2; rw = 1; end
            7'h17: begin src = 3; imm = 2; rw = 1; end
            7'h0F: ;
            default: ill = 1;
        endcase
        if (ill) begin rw = 0; mw = 0; mr = 0; mop = 0; br = 0; md = 0; end
        if (w[11:7] == 0) rw = 0;
        return {rw, mw, mr, mop, alu, src, imm, br, md, ill};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h5B};
        w = $urandom;
        w[6:0] = ops[$urandom_range(11, 0)];
        if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && w[13:12] == 2'b01)) begin
            case ($urandom_range(3, 0))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        if ($urandom_range(15, 0) == 0) w[1:0] = 2'b10;
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        in_valid = (srcq.size() > 0);
        if (in_valid) begin
            in_inst = srcq[0].inst;
            in_pc   = srcq[0].pc;
        end else begin
            in_inst = $urandom;
            in_pc   = $urandom;
        end
    endtask

    task automatic push(input logic [31:0] w);
        srcq.push_back('{pc: next_pc, inst: w});
        next_pc = next_pc + 32'd4;
        drive();
    endtask

    // One clock: check outputs against the model at the falling edge, then advance.
    task automatic tick();
        item_t e;
        logic [23:0] m, ra, rb;
        bit fire, acc;
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(!rst && expq.size() < 2));
        check("in_ready_nom", 64'(in_ready_b), 64'(!rst && expq.size() < 2));
        check("out_valid", 64'(out_valid), 64'(expq.size() > 0));
        check("out_valid_nom", 64'(out_valid_b), 64'(expq.size() > 0));
        fire = out_valid && out_ready;
        acc  = in_valid && in_ready;
        if (fire && expq.size() > 0) begin
            e = expq.pop_front();
            check("out_pc", 64'(out_pc), 64'(e.pc));
            check("out_inst", 64'(out_inst), 64'(e.inst));
            check("out_regs", 64'({out_rs1, out_rs2, out_rd}), 64'({e.inst[19:15], e.inst[24:20], e.inst[11:7]}));
            ra = ref_dec(e.inst, 1'b1);
            rb = ref_dec(e.inst, 1'b0);
            m = ra[0] ? 24'hFC00FF : 24'hFFFFFF;
            check("ctrl", 64'(ctrl_a & m), 64'(ra & m));
            m = rb[0] ? 24'hFC00FF : 24'hFFFFFF;
            check("ctrl_nom", 64'(ctrl_b & m), 64'(rb & m));
        end
        if (rst || flush) begin
            expq.delete();
            srcq.delete();
        end else if (acc && srcq.size() > 0) begin
            expq.push_back(srcq.pop_front());
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic single(input logic [31:0] w);
        push(w);
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive();
        run(2);
        check("rst_ctrl", 64'(ctrl_a), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        run(1);

        // addi latency and back-to-back stream
        out_ready = 1'b1;
        single(32'h0050_0093);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_fields", 64'({out_alu_op, out_alu_src, out_imm_op, out_reg_write, out_rd}),
              64'({4'b0000, 3'b010, 3'b001, 1'b1, 5'd1}));
        for (int i = 0; i < 6; i++) push(32'h0050_0093 + (32'(i) << 7));
        run(9);

        // backpressure: fill M and S, hold 3 cycles, release
        out_ready = 1'b0;
        pc0 = next_pc;
        for (int i = 0; i < 4; i++) push(rand_inst());
        run(3);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_head_pc", 64'(out_pc), 64'(pc0));
        out_ready = 1'b1;
        run(8);

        // directed decode cases
        single(32'h0081_2283);
        check("lw", 64'({out_mem_to_reg, out_reg_write, out_mem_op}), 64'({1'b1, 1'b1, 3'b011}));
        single(32'h0051_0023);
        check("sb", 64'({out_mem_write, out_mem_op}), 64'({1'b1, 3'b001}));
        single(32'h0020_F063);
        check("bgeu", 64'({out_alu_op, out_branch}), 64'({4'b1010, 3'b111}));
        single(32'h0220_81B3);
        check("mul", 64'({out_md_op, out_reg_write, out_illegal}), 64'({4'b1000, 1'b1, 1'b0}));
        check("mul_nom", 64'({out_md_op_b, out_reg_write_b, out_illegal_b}), 64'({4'b0000, 1'b0, 1'b1}));
        single(32'hFFFF_FFFF);
        check("ill_ones", 64'({out_illegal, out_reg_write, out_mem_write, out_mem_to_reg, out_mem_op, out_branch, out_md_op}),
              64'({1'b1, 13'd0}));
        single(32'h0000_0073);
        check("ecall", 64'({out_illegal, out_reg_write, out_mem_write, out_mem_to_reg, out_mem_op, out_branch, out_md_op}),
              64'({1'b1, 13'd0}));
        single(32'h0081_3283);
        check("lw_f3_011", 64'({out_illegal, out_reg_write, out_mem_write, out_mem_to_reg, out_mem_op, out_branch, out_md_op}),
              64'({1'b1, 13'd0}));
        single(32'h0020_8033);
        check("add_x0", 64'({out_reg_write, out_illegal}), 64'({1'b0, 1'b0}));
        single(32'h0000_006F);
        check("jal_x0", 64'({out_reg_write, out_branch}), 64'({1'b0, 3'b001}));
        run(3);

        // randomized stream with random backpressure
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            if (srcq.size() < 3 && $urandom_range(1, 0) == 1) push(rand_inst());
            tick();
        end
        out_ready = 1'b1;
        run(6);

        // flush with M and S full and a third instruction offered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rand_inst());
        run(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_full_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        run(3);

        // flush while an input handshake completes into an empty skid
        out_ready = 1'b0;
        push(rand_inst());
        push(rand_inst());
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_hs_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        run(3);

        // reset mid-stream, then resume
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rand_inst());
        run(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        push(32'h0050_0093);
        push(32'h0220_81B3);
        run(5);
        check("drained", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
